// File: rtl/alu_seq.sv
// alu_seq: registered W-bit ALU with {n,v,z,c} flag register and optional shift-add multiplier.
// Latency: single-cycle ops complete at the accept edge, so out_valid rises the next cycle. MUL completes W edges after accept.
// Backpressure: in_ready is low only while a MUL iterates; in_valid is ignored in that window.
//
// Optional feature macro: ALU_MUL_EN
//   defined   -> opcode 14 runs the W-cycle shift-add multiplier FSM
//   undefined -> opcode 14 completes in one cycle with err=1, f=0, f_hi=0, flags held
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  operation request / accept (accept = in_valid && in_ready at a rising edge)
//   s, a, b, cin    opcode, operands, external carry (used only when EXT_CARRY=1)
//   out_valid       one-cycle pulse when f/f_hi/flags/err have been updated
//   f, f_hi         result (low half for MUL), MUL high half (cleared by other result-writing ops)
//   flags           {n,v,z,c}
//   err             high with out_valid for an unsupported opcode
module alu_seq #(
    parameter int W         = 8,
    parameter int EXT_CARRY = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   s,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    output logic [W-1:0] f,
    output logic [W-1:0] f_hi,
    output logic [3:0]   flags,
    output logic         err
);

    // Opcode map
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_ROL = 4'd10;
    localparam logic [3:0] OP_ROR = 4'd11;
    localparam logic [3:0] OP_INC = 4'd12;
    localparam logic [3:0] OP_DEC = 4'd13;
    localparam logic [3:0] OP_MUL = 4'd14;
    localparam logic [3:0] OP_CMP = 4'd15;

    // Bit positions inside the {n,v,z,c} flag vector
    localparam int FC = 0;

    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] SMAX     = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN     = {1'b1, {(W-1){1'b0}}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t         state_q,     state_d;
    logic           out_valid_q, out_valid_d;
    logic           err_q,       err_d;
    logic [W-1:0]   f_q,         f_d;
    logic [W-1:0]   f_hi_q,      f_hi_d;
    logic [3:0]     flags_q,     flags_d;

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(W);

    // Multiplier datapath: {p_hi, p_lo} is the running product; p_lo starts
    // as the multiplier and is consumed LSB-first as the product shifts in.
    logic [W-1:0]   mcand_q,     mcand_d;
    logic [W-1:0]   p_hi_q,      p_hi_d;
    logic [W-1:0]   p_lo_q,      p_lo_d;
    logic [CW-1:0]  cnt_q,       cnt_d;

    logic [W-1:0]   mul_addend;
    logic [W:0]     mul_sum;
    logic [W-1:0]   mul_hi_next;
    logic [W-1:0]   mul_lo_next;
`endif

    // Carry source sampled together with the operands at the accept edge
    logic           cy;
    assign cy = (EXT_CARRY != 0) ? cin : flags_q[FC];

    // ------------------------------------------------------------------
    // Single-cycle ALU datapath
    // ------------------------------------------------------------------
    logic [W:0]     add_ext;
    logic [W:0]     sub_ext;
    logic [W-1:0]   alu_res;
    logic           alu_c;
    logic           alu_v;

    always_comb begin
        // Carry/borrow-in only participates for the chained variants
        add_ext = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, (s == OP_ADC) & cy};
        sub_ext = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, (s == OP_SBB) & cy};

        alu_res = '0;
        alu_c   = flags_q[FC];   // logical ops and INC/DEC leave c alone
        alu_v   = 1'b0;

        case (s)
            OP_ADD, OP_ADC: begin
                alu_res = add_ext[W-1:0];
                alu_c   = add_ext[W];
                alu_v   = (a[W-1] == b[W-1]) && (add_ext[W-1] != a[W-1]);
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                // Bit W of the extended difference is the borrow
                alu_res = sub_ext[W-1:0];
                alu_c   = sub_ext[W];
                alu_v   = (a[W-1] != b[W-1]) && (sub_ext[W-1] != a[W-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_SHL: begin
                alu_res = {a[W-2:0], 1'b0};
                alu_c   = a[W-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, a[W-1:1]};
                alu_c   = a[0];
            end
            OP_ROL: begin
                // Rotate through carry: W+1-bit ring {c, a}
                alu_res = {a[W-2:0], cy};
                alu_c   = a[W-1];
            end
            OP_ROR: begin
                alu_res = {cy, a[W-1:1]};
                alu_c   = a[0];
            end
            OP_INC: begin
                alu_res = a + ONE;
                alu_v   = (a == SMAX);
            end
            OP_DEC: begin
                alu_res = a - ONE;
                alu_v   = (a == SMIN);
            end
            default: begin
                // OP_MUL is handled by the sequencer below
                alu_res = '0;
            end
        endcase
    end

`ifdef ALU_MUL_EN
    // ------------------------------------------------------------------
    // One shift-add iteration: conditionally add the multiplicand into the
    // high half, then shift the whole {carry, p_hi, p_lo} right by one.
    // ------------------------------------------------------------------
    always_comb begin
        mul_addend  = p_lo_q[0] ? mcand_q : '0;
        mul_sum     = {1'b0, p_hi_q} + {1'b0, mul_addend};
        mul_hi_next = mul_sum[W:1];
        mul_lo_next = {mul_sum[0], p_lo_q[W-1:1]};
    end
`endif

    // ------------------------------------------------------------------
    // Sequencer / next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        err_d       = 1'b0;
        f_d         = f_q;
        f_hi_d      = f_hi_q;
        flags_d     = flags_q;
`ifdef ALU_MUL_EN
        mcand_d     = mcand_q;
        p_hi_d      = p_hi_q;
        p_lo_d      = p_lo_q;
        cnt_d       = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (s == OP_MUL) begin
`ifdef ALU_MUL_EN
                        state_d = ST_MUL;
                        mcand_d = a;
                        p_hi_d  = '0;
                        p_lo_d  = b;
                        cnt_d   = '0;
`else
                        // No multiplier in this build: report and clear result
                        out_valid_d = 1'b1;
                        err_d       = 1'b1;
                        f_d         = '0;
                        f_hi_d      = '0;
`endif
                    end else begin
                        out_valid_d = 1'b1;
                        // CMP only updates flags; f/f_hi keep the previous result
                        if (s != OP_CMP) begin
                            f_d    = alu_res;
                            f_hi_d = '0;
                        end
                        flags_d = {alu_res[W-1], alu_v, (alu_res == '0), alu_c};
                    end
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
                p_hi_d = mul_hi_next;
                p_lo_d = mul_lo_next;
                cnt_d  = cnt_q + 1'b1;
                // Last iteration writes the product straight into the result
                // registers so out_valid follows on the next cycle.
                if (cnt_q == CW'(W - 1)) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    f_d         = mul_lo_next;
                    f_hi_d      = mul_hi_next;
                    flags_d     = {mul_hi_next[W-1],
                                   1'b0,
                                   (mul_hi_next == '0) && (mul_lo_next == '0),
                                   (mul_hi_next != '0)};
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            f_q         <= '0;
            f_hi_q      <= '0;
            flags_q     <= '0;
`ifdef ALU_MUL_EN
            mcand_q     <= '0;
            p_hi_q      <= '0;
            p_lo_q      <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            f_q         <= f_d;
            f_hi_q      <= f_hi_d;
            flags_q     <= flags_d;
`ifdef ALU_MUL_EN
            mcand_q     <= mcand_d;
            p_hi_q      <= p_hi_d;
            p_lo_q      <= p_lo_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Without the multiplier the FSM never leaves IDLE, so in_ready is constant 1
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign f         = f_q;
    assign f_hi      = f_hi_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at W=8, EXT_CARRY=0.
// Drives inputs on the falling edge, samples outputs 1ns after the rising edge.
// Multiplier scenarios run when ALU_MUL_EN is defined, the unsupported-op path otherwise.
`timescale 1ns/1ps
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic [W-1:0] f;
    logic [W-1:0] f_hi;
    logic [3:0]   flags;
    logic         err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] ef;
        logic [3:0] efl;   // {n,v,z,c}
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    alu_seq #(.W(W), .EXT_CARRY(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .f         (f),
        .f_hi      (f_hi),
        .flags     (flags),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; s = '0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (f !== 8'h00) begin errors++; $display("FAIL reset_f: got %h expected 00", f); end
        checks++; if (f_hi !== 8'h00) begin errors++; $display("FAIL reset_f_hi: got %h expected 00", f_hi); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", flags); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Back-to-back single-cycle ops; the flag column tracks the carry chain
    // through the sequence (logical ops and INC/DEC keep the previous c).
    task automatic test_alu_table();
        vecs[0]  = '{4'd0,  8'd52,  8'd48,  8'd100, 4'b0000}; // ADD
        vecs[1]  = '{4'd2,  8'd48,  8'd52,  8'd252, 4'b1001}; // SUB borrow
        vecs[2]  = '{4'd15, 8'd7,   8'd7,   8'd252, 4'b0010}; // CMP, f held
        vecs[3]  = '{4'd0,  8'd200, 8'd100, 8'd44,  4'b0001}; // ADD carry out
        vecs[4]  = '{4'd1,  8'd1,   8'd1,   8'd3,   4'b0000}; // ADC with c=1
        vecs[5]  = '{4'd0,  8'd127, 8'd1,   8'd128, 4'b1100}; // ADD overflow
        vecs[6]  = '{4'd12, 8'd255, 8'd0,   8'd0,   4'b0010}; // INC wrap, c=0 kept
        vecs[7]  = '{4'd2,  8'd0,   8'd1,   8'd255, 4'b1001}; // SUB 0-1
        vecs[8]  = '{4'd12, 8'd255, 8'd0,   8'd0,   4'b0011}; // INC wrap, c=1 kept
        vecs[9]  = '{4'd13, 8'd0,   8'd0,   8'd255, 4'b1001}; // DEC wrap
        vecs[10] = '{4'd4,  8'hF0,  8'h3C,  8'h30,  4'b0001}; // AND
        vecs[11] = '{4'd6,  8'hFF,  8'h0F,  8'hF0,  4'b1001}; // XOR
        vecs[12] = '{4'd8,  8'h81,  8'h00,  8'h02,  4'b0001}; // SHL
        vecs[13] = '{4'd10, 8'h40,  8'h00,  8'h81,  4'b1000}; // ROL cy=1
        vecs[14] = '{4'd11, 8'h01,  8'h00,  8'h00,  4'b0011}; // ROR cy=0
        vecs[15] = '{4'd3,  8'd5,   8'd3,   8'd1,   4'b0000}; // SBB cy=1
        vecs[16] = '{4'd9,  8'h02,  8'h00,  8'h01,  4'b0000}; // SHR
        vecs[17] = '{4'd7,  8'h0F,  8'h00,  8'hF0,  4'b1000}; // NOT
        vecs[18] = '{4'd5,  8'h00,  8'h00,  8'h00,  4'b0010}; // OR zero
        vecs[19] = '{4'd2,  8'h80,  8'h01,  8'h7F,  4'b0100}; // SUB overflow
        vecs[20] = '{4'd13, 8'h80,  8'h00,  8'h7F,  4'b0100}; // DEC overflow
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            in_valid = 1'b1; s = vecs[i].op; a = vecs[i].va; b = vecs[i].vb;
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL vec%0d_out_valid: got %b expected 1", i, out_valid); end
            checks++; if (f !== vecs[i].ef) begin errors++; $display("FAIL vec%0d_f: got %h expected %h", i, f, vecs[i].ef); end
            checks++; if (flags !== vecs[i].efl) begin errors++; $display("FAIL vec%0d_flags: got %b expected %b", i, flags, vecs[i].efl); end
            checks++; if (f_hi !== 8'h00) begin errors++; $display("FAIL vec%0d_f_hi: got %h expected 00", i, f_hi); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL vec%0d_err: got %b expected 0", i, err); end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // With no request, out_valid stays low and the last result/flags hold
    task automatic test_idle_hold();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle%0d_out_valid: got %b expected 0", i, out_valid); end
            checks++; if (f !== 8'h7F) begin errors++; $display("FAIL idle%0d_f: got %h expected 7f", i, f); end
            checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL idle%0d_flags: got %b expected 0100", i, flags); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle%0d_in_ready: got %b expected 1", i, in_ready); end
        end
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul_basic();
        @(negedge clk);
        in_valid = 1'b1; s = 4'd14; a = 8'd52; b = 8'd48;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mul_accept_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_accept_out_valid: got %b expected 0", out_valid); end
        // Requests during the multiply must be ignored; flags must not move
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1; s = 4'd0; a = 8'd1; b = 8'd1;
            @(posedge clk);
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mul_busy%0d_in_ready: got %b expected 0", i, in_ready); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_busy%0d_out_valid: got %b expected 0", i, out_valid); end
            checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL mul_busy%0d_flags: got %b expected 0100", i, flags); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mul_done_out_valid: got %b expected 1", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_done_in_ready: got %b expected 1", in_ready); end
        checks++; if (f !== 8'hC0) begin errors++; $display("FAIL mul_done_f: got %h expected c0", f); end
        checks++; if (f_hi !== 8'h09) begin errors++; $display("FAIL mul_done_f_hi: got %h expected 09", f_hi); end
        checks++; if (flags !== 4'b0001) begin errors++; $display("FAIL mul_done_flags: got %b expected 0001", flags); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mul_done_err: got %b expected 0", err); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_after_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_mul_edges();
        logic [7:0] ma [2];
        logic [7:0] mb [2];
        logic [7:0] elo [2];
        logic [7:0] ehi [2];
        logic [3:0] efl [2];
        int cyc;
        ma[0] = 8'd255; mb[0] = 8'd255; elo[0] = 8'h01; ehi[0] = 8'hFE; efl[0] = 4'b1001;
        ma[1] = 8'd0;   mb[1] = 8'd37;  elo[1] = 8'h00; ehi[1] = 8'h00; efl[1] = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1; s = 4'd14; a = ma[i]; b = mb[i];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            cyc = 0;
            while (out_valid !== 1'b1 && cyc < 20) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            checks++; if (cyc != 8) begin errors++; $display("FAIL mul%0d_latency: got %0d cycles expected 8", i, cyc); end
            checks++; if (f !== elo[i]) begin errors++; $display("FAIL mul%0d_f: got %h expected %h", i, f, elo[i]); end
            checks++; if (f_hi !== ehi[i]) begin errors++; $display("FAIL mul%0d_f_hi: got %h expected %h", i, f_hi, ehi[i]); end
            checks++; if (flags !== efl[i]) begin errors++; $display("FAIL mul%0d_flags: got %b expected %b", i, flags, efl[i]); end
        end
        // A following single-cycle op clears f_hi
        @(negedge clk);
        in_valid = 1'b1; s = 4'd0; a = 8'd1; b = 8'd1;
        @(posedge clk);
        #1;
        checks++; if (f !== 8'd2) begin errors++; $display("FAIL post_mul_f: got %h expected 02", f); end
        checks++; if (f_hi !== 8'h00) begin errors++; $display("FAIL post_mul_f_hi: got %h expected 00", f_hi); end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        int pulses;
        @(negedge clk);
        in_valid = 1'b1; s = 4'd14; a = 8'd52; b = 8'd48;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmul_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmul_in_ready: got %b expected 1", in_ready); end
        checks++; if (f !== 8'h00) begin errors++; $display("FAIL rstmul_f: got %h expected 00", f); end
        checks++; if (f_hi !== 8'h00) begin errors++; $display("FAIL rstmul_f_hi: got %h expected 00", f_hi); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL rstmul_flags: got %b expected 0000", flags); end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rstmul_no_pulse: got %0d pulses expected 0", pulses); end
    endtask
`else
    task automatic test_mul_disabled();
        @(negedge clk);
        in_valid = 1'b1; s = 4'd14; a = 8'd52; b = 8'd48;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nomul_out_valid: got %b expected 1", out_valid); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL nomul_err: got %b expected 1", err); end
        checks++; if (f !== 8'h00) begin errors++; $display("FAIL nomul_f: got %h expected 00", f); end
        checks++; if (f_hi !== 8'h00) begin errors++; $display("FAIL nomul_f_hi: got %h expected 00", f_hi); end
        checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL nomul_flags: got %b expected 0100", flags); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nomul_in_ready: got %b expected 1", in_ready); end
        // Next op is accepted immediately and completes normally
        @(negedge clk);
        s = 4'd0; a = 8'd1; b = 8'd1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nomul_next_out_valid: got %b expected 1", out_valid); end
        checks++; if (f !== 8'd2) begin errors++; $display("FAIL nomul_next_f: got %h expected 02", f); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL nomul_next_err: got %b expected 0", err); end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset_clear();
        @(negedge clk);
        in_valid = 1'b1; s = 4'd2; a = 8'd0; b = 8'd1;   // f=ff, flags 1001
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (f !== 8'h00) begin errors++; $display("FAIL rstclr_f: got %h expected 00", f); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL rstclr_flags: got %b expected 0000", flags); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstclr_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstclr_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_alu_table();
        test_idle_hold();
`ifdef ALU_MUL_EN
        test_mul_basic();
        test_mul_edges();
        test_reset_mid_mul();
`else
        test_mul_disabled();
        test_reset_clear();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
